// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the shift-link receive path: bit order, collect states
// and the chunk-counter width helper.
package shift_deserializer_pkg;

  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic {
    COLLECT = 1'b0,
    LAST    = 1'b1
  } state_t;

  // The counter must reach CHUNKS itself, so it needs one bit above $clog2.
  function automatic int cnt_width(input int chunks);
    return $clog2(chunks) + 1;
  endfunction

endpackage

// File: rtl/shift_out_reg.sv
// Valid/ready holding stage for an assembled word and its chunk-count metadata.
module shift_out_reg #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIZE-1:0]  load_data,
  input  logic [CNT_W-1:0] load_chunks,
  input  logic             load_partial,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic [CNT_W-1:0] out_chunks,
  output logic             out_partial
);

  // A load only arrives when the register is empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_chunks  <= '0;
      out_partial <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= load_data;
      out_chunks  <= load_chunks;
      out_partial <= load_partial;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Receive end of the shifter link: packs SHIFTVAL-bit chunks, first chunk in the
// MSBs, into SIZE-bit words; in_last closes a short, left-aligned word early.
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int SHIFTVAL = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      clear,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [SHIFTVAL-1:0]                       in_chunk,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [SIZE-1:0]                           out_data,
  output logic [cnt_width(SIZE/SHIFTVAL)-1:0]       out_chunks,
  output logic                                      out_partial
);

  localparam int CHUNKS = SIZE / SHIFTVAL;
  localparam int CNT_W  = cnt_width(CHUNKS);

  // sr never holds more than CHUNKS-1 chunks; the closing chunk goes straight out.
  logic [SIZE-SHIFTVAL-1:0] sr;
  logic [CNT_W-1:0]         cnt;
  state_t                   state;
  logic                     close_pending;
  logic                     accept;
  logic                     close;
  logic [SIZE-1:0]          word;
  logic [CNT_W-1:0]         word_chunks;

  assign state         = (cnt == CNT_W'(CHUNKS - 1)) ? LAST : COLLECT;
  assign close_pending = in_valid && ((state == LAST) || in_last);
  assign in_ready      = clear || !close_pending || !out_valid || out_ready;
  assign accept        = in_valid && in_ready && !clear;
  assign close         = accept && ((state == LAST) || in_last);

  assign word        = {sr, in_chunk} << (SHIFTVAL * (CHUNKS - 1 - int'(cnt)));
  assign word_chunks = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (close) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= {sr[SIZE-2*SHIFTVAL-1:0], in_chunk};
      cnt <= cnt + CNT_W'(1);
    end
  end

  shift_out_reg #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (close),
    .load_data    (word),
    .load_chunks  (word_chunks),
    .load_partial (state != LAST),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_chunks   (out_chunks),
    .out_partial  (out_partial)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// Randomized and directed bench for shift_deserializer against a queue-based word model.
module tb_shift_deserializer;

  localparam int SIZE     = 32;
  localparam int SHIFTVAL = 2;
  localparam int CHUNKS   = SIZE / SHIFTVAL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_chunk = 2'b00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_chunks;
  logic        out_partial;

  shift_deserializer #(.SIZE(SIZE), .SHIFTVAL(SHIFTVAL)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_chunk    (in_chunk),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_chunks  (out_chunks),
    .out_partial (out_partial)
  );

  always #5 clk = ~clk;

  // Model: chunks of the word in progress, and the word currently offered.
  int          q[$];
  logic        mvalid   = 1'b0;
  logic [31:0] mdata    = '0;
  int          mchunks  = 0;
  logic        mpartial = 1'b0;
  logic        last_rdy = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // First chunk lands in bits [SIZE-1:SIZE-SHIFTVAL]; unused low bits stay zero.
  function automatic logic [31:0] model_word(input logic [1:0] ch);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++)
      w |= 32'(q[i]) << (SIZE - SHIFTVAL * (i + 1));
    w |= 32'(ch) << (SIZE - SHIFTVAL * (q.size() + 1));
    return w;
  endfunction

  task automatic step(input logic iv, input logic [1:0] ch, input logic il,
                      input logic ordy, input logic clr, input logic r);
    logic closing;
    logic exp_rdy;
    logic load;
    @(negedge clk);
    in_valid  = iv;
    in_chunk  = ch;
    in_last   = il;
    out_ready = ordy;
    clear     = clr;
    rst       = r;
    #1;
    closing  = iv && ((q.size() == CHUNKS - 1) || il);
    exp_rdy  = clr || !closing || !mvalid || ordy;
    last_rdy = in_ready;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    load = 1'b0;
    if (r) begin
      q.delete();
      mvalid = 1'b0; mdata = '0; mchunks = 0; mpartial = 1'b0;
    end else begin
      if (clr) begin
        q.delete();
      end else if (iv && exp_rdy) begin
        if (closing) begin
          mdata    = model_word(ch);
          mchunks  = q.size() + 1;
          mpartial = (q.size() + 1 < CHUNKS);
          load     = 1'b1;
          q.delete();
        end else begin
          q.push_back(int'(ch));
        end
      end
      if (load) mvalid = 1'b1;
      else if (mvalid && ordy) mvalid = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(mvalid));
    check("out_data", out_data, mdata);
    check("out_chunks", 32'(out_chunks), 32'(mchunks));
    check("out_partial", 32'(out_partial), 32'(mpartial));
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'b00, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic chunk(input logic [1:0] ch, input logic il, input logic ordy);
    step(1'b1, ch, il, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    int words;
    int stalls;

    // Reset values
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", out_data, 32'h0);

    // 11,10,01,00 repeated -> E4E4E4E4 one cycle after chunk 16
    for (int i = 0; i < 16; i++) begin
      chunk(2'(3 - (i % 4)), 1'b0, 1'b1);
      if (i < 15) check("t1_early_valid", 32'(out_valid), 32'd0);
    end
    check("t1_data", out_data, 32'hE4E4_E4E4);
    check("t1_chunks", 32'(out_chunks), 32'd16);
    check("t1_partial", 32'(out_partial), 32'd0);

    // 48 back-to-back chunks: three words, never back-pressured
    words = 0; stalls = 0;
    for (int i = 0; i < 48; i++) begin
      chunk(2'($urandom_range(0, 3)), 1'b0, 1'b1);
      if (out_valid) words++;
      if (!last_rdy) stalls++;
    end
    check("t2_words", 32'(words), 32'd3);
    check("t2_stalls", 32'(stalls), 32'd0);
    idle(1'b1);

    // Stall: word 1 held, 15 chunks accepted, 16th refused until out_ready
    for (int i = 0; i < 16; i++) chunk(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      chunk(2'($urandom_range(0, 3)), 1'b0, 1'b0);
      if (!last_rdy) stalls++;
    end
    check("t3_accepted", 32'(stalls), 32'd0);
    chunk(2'b10, 1'b0, 1'b0);
    check("t3_stall_rdy", 32'(last_rdy), 32'd0);
    chunk(2'b10, 1'b0, 1'b0);
    check("t3_still_stalled", 32'(last_rdy), 32'd0);
    chunk(2'b10, 1'b0, 1'b1);
    check("t3_release_rdy", 32'(last_rdy), 32'd1);
    check("t3_word2_valid", 32'(out_valid), 32'd1);
    idle(1'b1);

    // Short word: three 01 chunks with in_last on the third
    chunk(2'b01, 1'b0, 1'b1);
    chunk(2'b01, 1'b0, 1'b1);
    chunk(2'b01, 1'b1, 1'b1);
    check("t4_data", out_data, 32'h5400_0000);
    check("t4_chunks", 32'(out_chunks), 32'd3);
    check("t4_partial", 32'(out_partial), 32'd1);
    idle(1'b1);

    // Clear drops 8 collected chunks plus the chunk on the clear cycle
    for (int i = 0; i < 8; i++) chunk(2'b01, 1'b0, 1'b1);
    step(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    words = 0;
    for (int i = 0; i < 16; i++) begin
      chunk(2'b10, 1'b0, 1'b1);
      if (out_valid) words++;
    end
    check("t5_words", 32'(words), 32'd1);
    check("t5_data", out_data, 32'hAAAA_AAAA);
    check("t5_chunks", 32'(out_chunks), 32'd16);
    idle(1'b1);

    // Reset mid-word with a word held
    for (int i = 0; i < 16; i++) chunk(2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) chunk(2'b01, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data", out_data, 32'h0);
    for (int i = 0; i < 16; i++) chunk(2'(3 - (i % 4)), 1'b0, 1'b1);
    check("t6_word", out_data, 32'hE4E4_E4E4);
    check("t6_partial", 32'(out_partial), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 8),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
